stream_demux_1to2: RTL and testbench

- Buffered 1-to-2 demultiplexer for 100-bit words. It is the inverse of the team's 2-to-1 vector mux.
- One valid/ready input stream is steered by a per-word select to one of two valid/ready output streams.
- Each output has its own small FIFO, so a stalled consumer blocks only its own lane.
- Sits between a single producer and two consumers in the datapath. It also exposes per-lane delivered-word counters for the test harness.

---
 rtl/stream_demux_pkg.sv | 9 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/stream_demux_1to2.sv | 76 +++++++
 tb/tb_stream_demux_1to2.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the buffered 1-to-2 stream demultiplexer.
package stream_demux_pkg;
  localparam int WIDTH_DEFAULT = 100;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef logic [WIDTH_DEFAULT-1:0] word_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; rdata shows the head, or the last
// popped word (0 after reset) while empty.
module sync_fifo
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_last;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign rdata  = empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/stream_demux_1to2.sv
// Buffered 1-to-2 demux: steers each input word into one of two lane FIFOs and
// counts words delivered per lane.
module stream_demux_1to2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic             w_full0, w_full1;
  logic             w_empty0, w_empty1;
  logic             w_push0, w_push1;
  logic             w_pop0, w_pop1;
  logic             w_lane_full;
  logic [CNT_W-1:0] r_cnt0, r_cnt1;

  // Ready looks only at the addressed lane, so a stalled lane never blocks the other.
  assign w_lane_full = (in_sel == LANE1) ? w_full1 : w_full0;
  assign in_ready    = ~reset & ~w_lane_full;
  assign w_push0     = in_valid & in_ready & (in_sel == LANE0);
  assign w_push1     = in_valid & in_ready & (in_sel == LANE1);

  assign out0_valid = ~w_empty0;
  assign out1_valid = ~w_empty1;
  assign w_pop0     = out0_valid & out0_ready;
  assign w_pop1     = out1_valid & out1_ready;
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (w_push0),
    .pop   (w_pop0),
    .wdata (in_data),
    .rdata (out0_data),
    .full  (w_full0),
    .empty (w_empty0)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (w_push1),
    .pop   (w_pop1),
    .wdata (in_data),
    .rdata (out1_data),
    .full  (w_full1),
    .empty (w_empty1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_pop0) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_pop1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end
endmodule

// File: tb/tb_stream_demux_1to2.sv
// Bench for stream_demux_1to2: queue-based lane model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_stream_demux_1to2;
  import stream_demux_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  word_t            in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  word_t            out0_data;
  logic             out0_valid;
  logic             out0_ready;
  word_t            out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  stream_demux_1to2 #(.WIDTH(WIDTH_DEFAULT), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void check_w(string nm, word_t act, word_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endfunction

  function automatic void check_b(string nm, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endfunction

  function automatic void check_c(string nm, logic [CNT_W-1:0] act, logic [CNT_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endfunction

  // Behavioural model: one queue per lane, last-popped word, delivered counts.
  word_t            q0[$];
  word_t            q1[$];
  word_t            last0, last1;
  logic [CNT_W-1:0] m_cnt0, m_cnt1;
  bit               held = 1'b0;

  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      q0.delete();
      q1.delete();
      last0  = '0;
      last1  = '0;
      m_cnt0 = '0;
      m_cnt1 = '0;
      held   = 1'b0;
    end else begin
      acc = in_valid && ((in_sel ? q1.size() : q0.size()) < DEPTH);
      if (out0_ready && q0.size() > 0) begin
        last0  = q0.pop_front();
        m_cnt0 = m_cnt0 + 1'b1;
      end
      if (out1_ready && q1.size() > 0) begin
        last1  = q1.pop_front();
        m_cnt1 = m_cnt1 + 1'b1;
      end
      if (acc) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
      held = in_valid && !acc;
    end
  end

  bit   chk_en     = 1'b0;
  bit   stall_prev = 1'b0;
  logic sel_prev   = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check_b("in_ready", in_ready,
              !reset && ((in_sel ? q1.size() : q0.size()) < DEPTH));
      check_b("out0_valid", out0_valid, q0.size() > 0);
      check_w("out0_data", out0_data, (q0.size() > 0) ? q0[0] : last0);
      check_b("out1_valid", out1_valid, q1.size() > 0);
      check_w("out1_data", out1_data, (q1.size() > 0) ? q1[0] : last1);
      check_c("cnt0", cnt0, m_cnt0);
      check_c("cnt1", cnt1, m_cnt1);
      if (stall_prev)
        assert (in_sel == sel_prev) else $error("in_sel changed while input stalled");
      stall_prev = in_valid && !in_ready && !reset;
      sel_prev   = in_sel;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic rst_pulse();
    in_valid = 1'b0;
    reset    = 1'b1;
    cyc();
    reset    = 1'b0;
  endtask

  task automatic push(input logic s, input word_t d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      cyc();
      if (!held) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: lane %0d word %h not accepted within 50 cycles", s, d);
    end
    in_valid = 1'b0;
  endtask

  word_t pa, pb;

  initial begin
    pa = {25{4'hA}};
    pb = {25{4'h5}};
    reset = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b1; out1_ready = 1'b1;

    // Reset held for two cycles
    cyc();
    chk_en = 1'b1;
    cyc();
    check_b("rst in_ready", in_ready, 1'b0);
    check_b("rst out0_valid", out0_valid, 1'b0);
    check_b("rst out1_valid", out1_valid, 1'b0);
    check_c("rst cnt0", cnt0, 16'd0);
    check_c("rst cnt1", cnt1, 16'd0);
    check_w("rst out0_data", out0_data, '0);
    reset = 1'b0;
    cyc();
    check_b("post-rst in_ready", in_ready, 1'b1);

    // Single routing
    push(1'b0, pa);
    check_b("route0 valid", out0_valid, 1'b1);
    check_w("route0 data", out0_data, pa);
    check_b("route0 other lane", out1_valid, 1'b0);
    push(1'b1, pb);
    check_b("route1 valid", out1_valid, 1'b1);
    check_w("route1 data", out1_data, pb);
    idle(3);
    check_c("route cnt0", cnt0, 16'd1);
    check_c("route cnt1", cnt1, 16'd1);

    // Lane stall isolation
    rst_pulse();
    out0_ready = 1'b0;
    push(1'b0, word_t'(1));
    push(1'b0, word_t'(2));
    in_sel = 1'b0;
    #1;
    check_b("stall lane0 ready", in_ready, 1'b0);
    push(1'b1, word_t'(1));
    check_b("stall lane1 valid", out1_valid, 1'b1);
    check_w("stall lane1 data", out1_data, word_t'(1));
    check_w("stall lane0 head", out0_data, word_t'(1));
    out0_ready = 1'b1;
    push(1'b0, word_t'(3));
    idle(4);
    check_c("stall cnt0", cnt0, 16'd3);
    check_w("stall last0", out0_data, word_t'(3));

    // Full lane with simultaneous pop
    rst_pulse();
    out1_ready = 1'b0;
    push(1'b1, word_t'(10));
    push(1'b1, word_t'(11));
    out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = word_t'(12);
    #1;
    check_b("full ready", in_ready, 1'b0);
    cyc();
    check_b("full ready next", in_ready, 1'b1);
    check_w("full head", out1_data, word_t'(11));
    cyc();
    in_valid = 1'b0;
    idle(4);
    check_c("full cnt1", cnt1, 16'd3);
    check_w("full last1", out1_data, word_t'(12));

    // Toggling select
    rst_pulse();
    for (int i = 0; i < 10; i++) push(logic'(i % 2), word_t'(i));
    idle(4);
    check_c("toggle cnt0", cnt0, 16'd5);
    check_c("toggle cnt1", cnt1, 16'd5);
    check_w("toggle last0", out0_data, word_t'(8));
    check_w("toggle last1", out1_data, word_t'(9));

    // Reset mid-operation
    rst_pulse();
    out0_ready = 1'b0;
    push(1'b0, word_t'('h77));
    push(1'b0, word_t'('h88));
    check_b("midrst before", out0_valid, 1'b1);
    reset = 1'b1;
    cyc();
    check_b("midrst valid", out0_valid, 1'b0);
    check_c("midrst cnt0", cnt0, 16'd0);
    check_w("midrst data", out0_data, '0);
    reset = 1'b0;
    out0_ready = 1'b1;
    idle(3);
    check_b("midrst no reappear", out0_valid, 1'b0);
    check_c("midrst cnt0 after", cnt0, 16'd0);

    // Randomized traffic
    rst_pulse();
    for (int c = 0; c < 3000; c++) begin
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = logic'($urandom_range(0, 1));
        in_data  = word_t'({$urandom, $urandom, $urandom, $urandom});
      end
      out0_ready = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      out1_ready = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 399) == 0);
      cyc();
    end
    reset = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    idle(6);
    check_b("drain out0_valid", out0_valid, 1'b0);
    check_b("drain out1_valid", out1_valid, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
